// File: rtl/covariance_predict_engine.sv
// Kalman time-update engine: P <= A*P*A' + Q on one serial MAC, with round-half-up,
// saturating element writes, a sticky overflow flag and optional symmetrisation.
//  state | meaning
//  IDLE  | wait for init_load (P <= P0) or start
//  MUL1  | T = A*P, one product per cycle
//  MUL2  | Pn = T*A' + Q, one product per cycle
//  SYM   | commit Pn (optionally symmetrised) into P
//  DONE  | one-cycle done pulse, back to IDLE
module covariance_predict_engine #(
    parameter int WIDTH  = 16,
    parameter int FRAC   = 8,
    parameter int nos    = 4,
    parameter int SYM_EN = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clk_en,
    input  logic                         init_load,
    input  logic                         start,
    input  logic [WIDTH*nos*nos-1:0]     A,
    input  logic [WIDTH*nos*nos-1:0]     Q,
    input  logic [WIDTH*nos*nos-1:0]     P0,
    output logic [WIDTH*nos*nos-1:0]     P,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow
);
    localparam int MW = WIDTH * nos * nos;
    localparam int CW = $clog2(nos);
    localparam int AW = 2 * WIDTH + $clog2(nos) + 1;
    localparam logic [CW-1:0] LAST = CW'(nos - 1);
    localparam logic signed [AW-1:0] HALF  = AW'(64'sd1 <<< (FRAC - 1));
    localparam logic signed [AW-1:0] MAX_A = AW'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
    localparam logic signed [AW-1:0] MIN_A = ~MAX_A;
    localparam logic signed [WIDTH-1:0] MAX_W = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MUL1, S_MUL2, S_SYM, S_DONE} state_t;

    state_t                  state;
    logic signed [WIDTH-1:0] p_m  [nos][nos];
    logic signed [WIDTH-1:0] t_m  [nos][nos];
    logic signed [WIDTH-1:0] pn_m [nos][nos];
    logic [CW-1:0]           ci, cj, ck;
    logic signed [AW-1:0]    acc, base, acc_next, rounded;
    logic signed [WIDTH-1:0] op_a, op_b, q_el, res;
    logic signed [2*WIDTH-1:0] prod;
    logic                    sat;

    function automatic logic signed [WIDTH-1:0] elem(input logic [MW-1:0] m,
                                                     input logic [CW-1:0] r,
                                                     input logic [CW-1:0] c);
        return m[(int'(r) * nos + int'(c)) * WIDTH +: WIDTH];
    endfunction

    function automatic logic signed [WIDTH-1:0] avg(input logic signed [WIDTH-1:0] x,
                                                    input logic signed [WIDTH-1:0] y);
        logic signed [WIDTH:0] s;
        s = {x[WIDTH-1], x} + {y[WIDTH-1], y};
        return WIDTH'(s >>> 1);
    endfunction

    // MUL1 multiplies A[i][k]*P[k][j]; MUL2 multiplies T[i][k]*A[j][k] on a Q-seeded sum
    always_comb begin
        op_a = '0;
        op_b = '0;
        if (state == S_MUL2) begin
            op_a = t_m[ci][ck];
            op_b = elem(A, cj, ck);
        end else begin
            op_a = elem(A, ci, ck);
            op_b = p_m[ck][cj];
        end
        prod = op_a * op_b;
        q_el = elem(Q, ci, cj);
        if (ck == '0)
            base = (state == S_MUL2) ? ({{(AW-WIDTH){q_el[WIDTH-1]}}, q_el} <<< FRAC) : '0;
        else
            base = acc;
        acc_next = base + {{(AW-2*WIDTH){prod[2*WIDTH-1]}}, prod};
        rounded  = (acc_next + HALF) >>> FRAC;
        sat      = 1'b0;
        res      = rounded[WIDTH-1:0];
        if (rounded > MAX_A) begin
            sat = 1'b1;
            res = MAX_W;
        end else if (rounded < MIN_A) begin
            sat = 1'b1;
            res = MIN_W;
        end
    end

    always_comb begin
        P = '0;
        for (int r = 0; r < nos; r++)
            for (int c = 0; c < nos; c++)
                P[(r*nos+c)*WIDTH +: WIDTH] = p_m[r][c];
    end

    always_ff @(posedge clk) begin
        if (clk_en) begin
            if (!reset_n) begin
                state    <= S_IDLE;
                ci       <= '0;
                cj       <= '0;
                ck       <= '0;
                acc      <= '0;
                busy     <= 1'b0;
                done     <= 1'b0;
                overflow <= 1'b0;
                for (int r = 0; r < nos; r++)
                    for (int c = 0; c < nos; c++) begin
                        p_m[r][c]  <= '0;
                        t_m[r][c]  <= '0;
                        pn_m[r][c] <= '0;
                    end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (init_load) begin
                            for (int r = 0; r < nos; r++)
                                for (int c = 0; c < nos; c++)
                                    p_m[r][c] <= P0[(r*nos+c)*WIDTH +: WIDTH];
                        end else if (start) begin
                            overflow <= 1'b0;
                            ci       <= '0;
                            cj       <= '0;
                            ck       <= '0;
                            busy     <= 1'b1;
                            state    <= S_MUL1;
                        end
                    end
                    S_MUL1, S_MUL2: begin
                        acc <= acc_next;
                        if (ck == LAST) begin
                            if (state == S_MUL1) t_m[ci][cj]  <= res;
                            else                 pn_m[ci][cj] <= res;
                            if (sat) overflow <= 1'b1;
                        end
                        ck <= ck + CW'(1);
                        if (ck == LAST) begin
                            ck <= '0;
                            cj <= cj + CW'(1);
                            if (cj == LAST) begin
                                cj <= '0;
                                ci <= ci + CW'(1);
                                if (ci == LAST) begin
                                    ci    <= '0;
                                    state <= (state == S_MUL1) ? S_MUL2 : S_SYM;
                                end
                            end
                        end
                    end
                    S_SYM: begin
                        for (int r = 0; r < nos; r++)
                            for (int c = 0; c < nos; c++)
                                p_m[r][c] <= (SYM_EN != 0) ? avg(pn_m[r][c], pn_m[c][r])
                                                           : pn_m[r][c];
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                    S_DONE: begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_covariance_predict_engine.sv
// Bench for covariance_predict_engine: matrix-level reference model with latency counting,
// directed scenarios plus randomized runs with random clock-enable stalls.
module tb_covariance_predict_engine;
    localparam int W  = 16;
    localparam int F  = 8;
    localparam int N  = 4;
    localparam int VW = W * N * N;
    localparam int LAT = 2 * N * N * N + 2;
    localparam longint MAXV = (longint'(1) << (W - 1)) - 1;
    localparam longint MINV = -MAXV - 1;

    logic clk = 0, reset_n = 0, clk_en = 1, init_load = 0, start = 0;
    logic [VW-1:0] A = '0, Q = '0, P0 = '0;
    logic [VW-1:0] p1, p0o;
    logic busy1, done1, ovf1, busy0, done0, ovf0;

    int checks = 0, failures = 0;
    bit chk_en = 0;

    covariance_predict_engine #(.WIDTH(W), .FRAC(F), .nos(N), .SYM_EN(1)) dut (
        .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .init_load(init_load), .start(start),
        .A(A), .Q(Q), .P0(P0), .P(p1), .busy(busy1), .done(done1), .overflow(ovf1));

    covariance_predict_engine #(.WIDTH(W), .FRAC(F), .nos(N), .SYM_EN(0)) dut_nosym (
        .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .init_load(init_load), .start(start),
        .A(A), .Q(Q), .P0(P0), .P(p0o), .busy(busy0), .done(done0), .overflow(ovf0));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic longint el(input logic [VW-1:0] m, input int r, input int c);
        return longint'($signed(m[(r*N+c)*W +: W]));
    endfunction

    function automatic logic [W-1:0] pel(input logic [VW-1:0] m, input int r, input int c);
        return m[(r*N+c)*W +: W];
    endfunction

    function automatic logic [VW-1:0] diag(input int v);
        logic [VW-1:0] m = '0;
        for (int i = 0; i < N; i++) m[(i*N+i)*W +: W] = W'(v);
        return m;
    endfunction

    function automatic longint rnd_sat(input longint s, inout bit ov);
        longint r = (s + (longint'(1) <<< (F - 1))) >>> F;
        if (r > MAXV) begin ov = 1; return MAXV; end
        if (r < MINV) begin ov = 1; return MINV; end
        return r;
    endfunction

    // Whole-matrix reference: T = A*P, Pn = T*A' + Q, then optional (Pn+Pn')/2
    function automatic logic [VW-1:0] predict(input logic [VW-1:0] a, input logic [VW-1:0] q,
                                              input logic [VW-1:0] p, input bit sym, output bit ov);
        longint t[N][N];
        longint pn[N][N];
        longint s, v;
        logic [VW-1:0] r = '0;
        ov = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int k = 0; k < N; k++) s += el(a, i, k) * el(p, k, j);
                t[i][j] = rnd_sat(s, ov);
            end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s = el(q, i, j) <<< F;
                for (int k = 0; k < N; k++) s += t[i][k] * el(a, j, k);
                pn[i][j] = rnd_sat(s, ov);
            end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                v = sym ? (pn[i][j] + pn[j][i]) >>> 1 : pn[i][j];
                r[(i*N+j)*W +: W] = W'(v);
            end
        return r;
    endfunction

    logic [VW-1:0] e_p1 = '0, e_p0 = '0, res1 = '0, res0 = '0;
    bit e_busy = 0, e_done = 0, e_ov1 = 0, e_ov0 = 0, r_ov1 = 0, r_ov0 = 0, ovf_known = 0;
    int cnt = 0;

    // Model advances only on enabled edges; the result lands LAT-1 enabled edges after start
    always @(posedge clk) begin
        if (clk_en) begin
            if (!reset_n) begin
                e_p1 = '0; e_p0 = '0; e_busy = 0; e_done = 0;
                e_ov1 = 0; e_ov0 = 0; ovf_known = 1;
            end else if (e_busy) begin
                cnt++;
                if (cnt == LAT - 1) begin
                    e_p1 = res1; e_p0 = res0; e_done = 1;
                    e_ov1 = r_ov1; e_ov0 = r_ov0; ovf_known = 1;
                end else if (cnt == LAT) begin
                    e_done = 0; e_busy = 0;
                end
            end else if (init_load) begin
                e_p1 = P0; e_p0 = P0;
            end else if (start) begin
                res1 = predict(A, Q, e_p1, 1'b1, r_ov1);
                res0 = predict(A, Q, e_p0, 1'b0, r_ov0);
                e_busy = 1; cnt = 0; ovf_known = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", VW'(busy1), VW'(e_busy));
            chk("busy_nosym", VW'(busy0), VW'(e_busy));
            chk("done", VW'(done1), VW'(e_done));
            chk("done_nosym", VW'(done0), VW'(e_done));
            chk("p_sym", p1, e_p1);
            chk("p_nosym", p0o, e_p0);
            if (ovf_known) begin
                chk("overflow", VW'(ovf1), VW'(e_ov1));
                chk("overflow_nosym", VW'(ovf0), VW'(e_ov0));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic load(input logic [VW-1:0] m);
        P0 = m; init_load = 1; tick; init_load = 0;
    endtask

    // mode 0: plain, 1: random clk_en stalls, 2: ignored pulses in MUL1 + 20-cycle stall in MUL2
    task automatic run(input int mode, output int lat);
        bit seen = 0;
        start = 1; tick; start = 0;
        lat = 0;
        for (int n = 1; n <= 2000; n++) begin
            @(negedge clk);
            lat = n;
            if (n == 1) begin
                chk("busy_rises", VW'(busy1), VW'(1));
                chk("ovf_clear_at_start", VW'(ovf1), VW'(0));
            end
            if (done1) begin seen = 1; break; end
            if (mode == 1) clk_en = ($urandom_range(0, 3) != 0);
            if (mode == 2) begin
                if (n == 20) begin start = 1; init_load = 1; P0 = diag(999); end
                if (n == 21) begin start = 0; init_load = 0; end
                if (n == 80) clk_en = 0;
                if (n == 100) clk_en = 1;
            end
        end
        clk_en = 1;
        if (!seen) begin
            checks++; failures++;
            $display("FAIL done_timeout actual=none required=done within 2000 cycles");
        end
        tick;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=hung required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, dcnt;
        logic [VW-1:0] m;
        tick;
        chk_en = 1;
        tick;
        reset_n = 1;
        chk("reset_p", p1, '0);
        chk("reset_busy", VW'(busy1), VW'(0));

        A = diag(256); Q = '0; load(diag(256));
        run(0, lat);
        chk("identity_latency", VW'(lat), VW'(130));
        chk("identity_p", p1, diag(256));
        chk("identity_ovf", VW'(ovf1), VW'(0));

        A = diag(512); Q = diag(128); load(diag(256));
        run(0, lat);
        chk("scale_p", p1, diag(1152));

        A = diag(25600); Q = '0; load(diag(25600));
        run(0, lat);
        chk("sat_p00", VW'(pel(p1, 0, 0)), VW'(32767));
        chk("sat_ovf", VW'(ovf1), VW'(1));
        A = diag(256);
        run(0, lat);
        chk("sat_rerun_ovf", VW'(ovf1), VW'(0));
        chk("sat_rerun_p", p1, diag(32767));

        m = diag(256); m[(0*N+1)*W +: W] = 16'd256;
        A = diag(256); Q = '0; load(m);
        run(0, lat);
        chk("sym_p01", VW'(pel(p1, 0, 1)), VW'(128));
        chk("sym_p10", VW'(pel(p1, 1, 0)), VW'(128));
        chk("nosym_p01", VW'(pel(p0o, 0, 1)), VW'(256));
        chk("nosym_p10", VW'(pel(p0o, 1, 0)), VW'(0));

        A = diag(512); Q = diag(128); load(diag(256));
        run(2, lat);
        chk("stall_latency", VW'(lat), VW'(150));
        chk("stall_p", p1, diag(1152));

        load(diag(256));
        start = 1; tick; start = 0;
        repeat (79) @(negedge clk);
        reset_n = 0;
        @(negedge clk);
        reset_n = 1;
        chk("rst_busy", VW'(busy1), VW'(0));
        chk("rst_p", p1, '0);
        chk("rst_ovf", VW'(ovf1), VW'(0));
        dcnt = 0;
        repeat (140) begin
            @(negedge clk);
            if (done1) dcnt++;
        end
        chk("rst_no_done", VW'(dcnt), VW'(0));
        tick;
        load(diag(256));
        run(0, lat);
        chk("rst_rerun_p", p1, diag(1152));

        for (int t = 0; t < 10; t++) begin
            int mag;
            mag = (t % 3 == 2) ? 20000 : 400;
            for (int i = 0; i < N * N; i++) begin
                A[i*W +: W]  = W'(int'($urandom_range(0, 2 * mag)) - mag);
                Q[i*W +: W]  = W'(int'($urandom_range(0, 2 * mag)) - mag);
                m[i*W +: W]  = W'(int'($urandom_range(0, 2 * mag)) - mag);
            end
            load(m);
            run(1, lat);
        end

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
